// File: rtl/btb_sat_pkg.sv
// btb_sat shared types: direction counter states, allocation value, flush FSM states.
// The entry struct is built in btb_sat from these types and its width localparams.
package btb_sat_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_ALLOC = WT;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/btb_sat_ctr.sv
// 2-bit saturating direction counter step: taken counts up, not-taken counts down.
module btb_sat_ctr
    import btb_sat_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr_next
);

    always_comb begin
        o_ctr_next = i_ctr;
        if (i_taken && i_ctr != ST)
            o_ctr_next = ctr_e'(2'(i_ctr + 2'd1));
        else if (!i_taken && i_ctr != SNT)
            o_ctr_next = ctr_e'(2'(i_ctr - 2'd1));
    end

endmodule

// File: rtl/btb_sat.sv
// Branch target buffer with 2-bit direction counters and a one-entry-per-cycle flush.
// Define BTB_SAT_BYPASS_EN to forward a same-cycle update into the lookup path.
module btb_sat
    import btb_sat_pkg::*;
#(
    parameter  int NUM_ENTRIES = 64,
    parameter  int ADDR_W      = 32,
    localparam int IDX_W       = $clog2(NUM_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    output logic [ADDR_W-1:0] next_pc,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              flush,
    output logic              busy
);

    localparam int TAG_W = ADDR_W - IDX_W - 2;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        ctr_e              ctr;
        logic [ADDR_W-1:0] target;
    } entry_t;

    logic [NUM_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag [NUM_ENTRIES];
    ctr_e                   r_ctr [NUM_ENTRIES];
    logic [ADDR_W-1:0]      r_tgt [NUM_ENTRIES];

    state_e     r_state;
    state_e     w_state_nxt;
    logic [IDX_W-1:0] r_fidx;
    logic [IDX_W-1:0] w_fidx_nxt;
    logic       w_clr;

    logic [IDX_W-1:0] w_lidx;
    logic [IDX_W-1:0] w_uidx;
    logic [TAG_W-1:0] w_ltag;
    logic [TAG_W-1:0] w_utag;
    entry_t     w_lent;
    entry_t     w_uent;
    logic       w_upd_en;
    logic       w_uhit;
    ctr_e       w_ctr_nxt;
    logic       w_hit;
    ctr_e       w_ctr;
    logic [ADDR_W-1:0] w_tgt;
    logic       w_unused;

    assign w_lidx = lookup_pc[IDX_W+1:2];
    assign w_ltag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign w_uidx = upd_pc[IDX_W+1:2];
    assign w_utag = upd_pc[ADDR_W-1:IDX_W+2];
    assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign w_lent = '{valid: r_valid[w_lidx], tag: r_tag[w_lidx],
                      ctr: r_ctr[w_lidx], target: r_tgt[w_lidx]};
    assign w_uent = '{valid: r_valid[w_uidx], tag: r_tag[w_uidx],
                      ctr: r_ctr[w_uidx], target: r_tgt[w_uidx]};

    // Updates are dropped while flushing and on the cycle a flush is accepted
    assign w_upd_en = upd_valid && r_state == IDLE && !flush && !rst;
    assign w_uhit   = w_uent.valid && w_uent.tag == w_utag;

    btb_sat_ctr u_ctr (
        .i_ctr      (w_uent.ctr),
        .i_taken    (upd_taken),
        .o_ctr_next (w_ctr_nxt)
    );

    always_comb begin
        w_hit = 1'b0;
        w_ctr = w_lent.ctr;
        w_tgt = w_lent.target;
        if (r_state == IDLE && w_lent.valid && w_lent.tag == w_ltag)
            w_hit = 1'b1;
`ifdef BTB_SAT_BYPASS_EN
        if (w_upd_en && w_lidx == w_uidx && w_ltag == w_utag) begin
            if (w_uhit) begin
                w_hit = 1'b1;
                w_ctr = w_ctr_nxt;
                if (upd_taken)
                    w_tgt = upd_target;
            end else if (upd_taken) begin
                w_hit = 1'b1;
                w_ctr = CTR_ALLOC;
                w_tgt = upd_target;
            end
        end
`endif
    end

    assign pred_hit    = w_hit;
    assign pred_taken  = w_hit && w_ctr[1];
    assign pred_target = w_hit ? w_tgt : '0;
    assign next_pc     = pred_taken ? w_tgt : lookup_pc + ADDR_W'(4);
    assign busy        = r_state == FLUSH;

    always_comb begin
        w_state_nxt = r_state;
        w_fidx_nxt  = r_fidx;
        w_clr       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (flush) begin
                    w_state_nxt = FLUSH;
                    w_fidx_nxt  = '0;
                end
            end
            FLUSH: begin
                w_clr      = 1'b1;
                w_fidx_nxt = r_fidx + IDX_W'(1);
                if (r_fidx == IDX_W'(NUM_ENTRIES - 1))
                    w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_fidx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_fidx  <= w_fidx_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_valid <= '0;
        else if (w_clr)
            r_valid[r_fidx] <= 1'b0;
        else if (w_upd_en && !w_uhit && upd_taken)
            r_valid[w_uidx] <= 1'b1;
    end

    // Payload storage is deliberately left unreset; valid gates every use
    always_ff @(posedge clk) begin
        if (w_upd_en) begin
            if (w_uhit) begin
                r_ctr[w_uidx] <= w_ctr_nxt;
                if (upd_taken)
                    r_tgt[w_uidx] <= upd_target;
            end else if (upd_taken) begin
                r_tag[w_uidx] <= w_utag;
                r_ctr[w_uidx] <= CTR_ALLOC;
                r_tgt[w_uidx] <= upd_target;
            end
        end
    end

endmodule

// File: tb/tb_btb_sat.sv
// Directed self-checking bench for btb_sat.
// 64 entries, 32-bit PCs, optional bypass.
module tb_btb_sat;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] lookup_pc = '0;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic [31:0] next_pc;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        flush = 1'b0;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int nb;

  btb_sat #(.NUM_ENTRIES(64), .ADDR_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .next_pc     (next_pc),
    .upd_valid   (upd_valid),
    .upd_pc      (upd_pc),
    .upd_taken   (upd_taken),
    .upd_target  (upd_target),
    .flush       (flush),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string t,
                     input logic [31:0] o,
                     input logic [31:0] e);
    n_tests++;
    if (o !== e) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             t, o, e);
    end
  endtask

  task automatic upd(input logic [31:0] pc,
                     input logic tk,
                     input logic [31:0] tgt);
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    upd_valid  = 1'b1;
    @(posedge clk);
    #1;
    upd_valid  = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    lookup_pc = pc;
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    look(32'h104);
    chk("rst_hit", pred_hit, 1'b0);
    chk("rst_taken", pred_taken, 1'b0);
    chk("rst_target", pred_target, 32'h0);
    chk("rst_next", next_pc, 32'h108);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    upd(32'h104, 1'b1, 32'h400);
    look(32'h104);
    chk("alloc_hit", pred_hit, 1'b1);
    chk("alloc_taken", pred_taken, 1'b1);
    chk("alloc_next", next_pc, 32'h400);

    upd(32'h104, 1'b0, 32'hBAD);
    look(32'h104);
    chk("wnt_taken", pred_taken, 1'b0);
    chk("wnt_next", next_pc, 32'h108);
    chk("wnt_hit", pred_hit, 1'b1);
    upd(32'h104, 1'b0, 32'hBAD);
    upd(32'h104, 1'b0, 32'hBAD);
    upd(32'h104, 1'b1, 32'h400);
    look(32'h104);
    chk("snt_sat_taken", pred_taken, 1'b0);
    upd(32'h104, 1'b1, 32'h400);
    look(32'h104);
    chk("wt_taken", pred_taken, 1'b1);
    chk("wt_next_nt_tgt_kept", next_pc, 32'h400);
    upd(32'h104, 1'b1, 32'h440);
    upd(32'h104, 1'b1, 32'h440);
    upd(32'h104, 1'b0, 32'hBAD);
    look(32'h104);
    chk("st_sat_taken", pred_taken, 1'b1);
    chk("tgt_overwrite", next_pc, 32'h440);
    upd(32'h104, 1'b0, 32'hBAD);
    look(32'h104);
    chk("st_down2_taken", pred_taken, 1'b0);
    chk("st_down2_next", next_pc, 32'h108);

    upd(32'h008, 1'b0, 32'h123);
    look(32'h008);
    chk("nt_miss_noalloc", pred_hit, 1'b0);

    upd(32'h204, 1'b1, 32'h800);
    look(32'h104);
    chk("alias_old_hit", pred_hit, 1'b0);
    chk("alias_old_next", next_pc, 32'h108);
    chk("alias_old_tgt", pred_target, 32'h0);
    look(32'h204);
    chk("alias_new_next", next_pc, 32'h800);

    look(32'hFFFF_FFFC);
    chk("wrap_next", next_pc, 32'h0);

    upd(32'h100, 1'b1, 32'hA00);
    upd(32'h1FC, 1'b1, 32'hB00);
    look(32'h1FC);
    chk("pre_flush_next", next_pc, 32'hB00);
    flush      = 1'b1;
    upd_valid  = 1'b1;
    upd_pc     = 32'h008;
    upd_taken  = 1'b1;
    upd_target = 32'hC00;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    upd_valid = 1'b0;
    nb = 0;
    for (int c = 0; c < 100; c++) begin
      if (!busy) break;
      nb++;
      if (c == 5) begin
        look(32'h1FC);
        chk("mid_flush_hit", pred_hit, 1'b0);
        chk("mid_flush_next", next_pc, 32'h200);
      end
      flush = (c == 20);
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    if (nb >= 100) begin
      n_fail++;
      $error("FAIL flush_wait: busy never fell");
    end
    chk("flush_busy_cycles", nb, 64);
    chk("flush_done_busy", busy, 1'b0);
    look(32'h100);
    chk("post_flush_100", next_pc, 32'h104);
    look(32'h1FC);
    chk("post_flush_1fc", pred_hit, 1'b0);
    look(32'h008);
    chk("flush_upd_dropped", pred_hit, 1'b0);

    upd(32'h1FC, 1'b1, 32'hB00);
    look(32'h1FC);
    chk("pre_rst_hit", pred_hit, 1'b1);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush10_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_hit", pred_hit, 1'b0);
    chk("rst_mid_tgt", pred_target, 32'h0);
    chk("rst_mid_next", next_pc, 32'h200);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_hit", pred_hit, 1'b0);
    upd(32'h104, 1'b1, 32'h500);
    look(32'h104);
    chk("post_rst_upd", next_pc, 32'h500);

    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    lookup_pc  = 32'h104;
    upd_pc     = 32'h104;
    upd_taken  = 1'b1;
    upd_target = 32'h300;
    upd_valid  = 1'b1;
    #1;
`ifdef BTB_SAT_BYPASS_EN
    chk("same_cyc_next", next_pc, 32'h300);
    chk("same_cyc_hit", pred_hit, 1'b1);
`else
    chk("same_cyc_next", next_pc, 32'h108);
    chk("same_cyc_hit", pred_hit, 1'b0);
`endif
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    #1;
    chk("next_cyc_next", next_pc, 32'h300);
    chk("next_cyc_hit", pred_hit, 1'b1);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
